byte_rd_arbiter: RTL
====================

Name: byte_rd_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared byte-select read path (the 72-bit register-bank bus feeding the 8-bit byte selector).
- Owns the select input of the byte selector and captures the selected byte into a registered return path per requester.
- Sits between the bank/selector and two consumers, e.g. the datapath read stage and the debug/display scanner.
- Clamps out-of-range addresses, because the selector has no defined output for select values above 8.

Parameters:
DATA_W, 8, width of one selected byte
SEL_W, 4, width of address/select
MAX_SEL, 8, highest valid select value; 0 is valid and reads as zero

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_a  in  1  requester A read request, level, held until ack_a
addr_a  in  SEL_W  requester A byte address, stable while req_a high
ack_a  out  1  one-cycle pulse: data_a/err_a valid
data_a  out  DATA_W  registered read data for A
err_a  out  1  address out of range on the acked transfer
req_b, addr_b, ack_b, data_b, err_b  as A, for requester B
mux_sel  out  SEL_W  registered select driven to the byte selector
mux_data  in  DATA_W  byte selector output (combinational from mux_sel)
busy  out  1  high in SEL and ACK states

Behaviour:
- Reset (async, rst_n=0): state IDLE, mux_sel=0, ack_a=ack_b=0, data_a=data_b=0, err_a=err_b=0, busy=0, last_grant=B, so A wins the first tie.
- FSM states:
  - IDLE: if any req is high, pick a winner, register mux_sel and the winner id, go to SEL. Otherwise stay.
  - SEL: mux_sel is stable and mux_data settles. At the clock edge, load the winner's data register from mux_data and go to ACK.
  - ACK: winner's ack=1 for exactly this cycle, update last_grant, go to IDLE.
- Arbitration happens only in IDLE.
  - One req high: that requester wins.
  - Both high: the requester not equal to last_grant wins (strict alternation under contention).
- Latency:
  - Request sampled in IDLE at edge N, ack high during cycle N+2.
  - Back-to-back throughput is one transfer per 3 cycles.
- Handshake:
  - Requester holds req and addr until it sees ack.
  - If req is still high in the cycle after ack, it is treated as a new request.
  - addr changes while req is high and not yet acked are undefined usage; the arbiter samples addr only in IDLE.
- Address clamp:
  - addr > MAX_SEL: mux_sel=0, winner's data register loaded with 0, err=1 with ack.
  - Otherwise err=0 with ack.
  - addr=0 returns 0 (selector constant) with err=0.
- Hold rules:
  - data_x and err_x hold their value until the next ack of the same requester.
  - The loser's outputs are never disturbed.
- mux_sel holds its last value in IDLE; no glitching to 0.
- Reset mid-transfer (SEL or ACK): abort immediately, no ack. Requesters must re-request.

Optional Feature:
BYTE_RD_ARBITER_STATS_EN
- Defined:
  - Adds outputs gcnt_a, gcnt_b (8 bits each): saturating counts of acks per requester, reset to 0, increment in the ACK cycle, stick at 255.
  - Adds conflict_cnt (8 bits, saturating): increments when both reqs are high in an IDLE arbitration cycle.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package byte_rd_arbiter_pkg:
  - state enum {IDLE, SEL, ACK}
  - requester id enum {REQ_A, REQ_B}
  - constants DATA_W, SEL_W, MAX_SEL defaults
  - saturating counter width constant
- Sub-module rr_pick2: combinational 2-way round-robin picker (req_a, req_b, last_grant -> grant_valid, grant_id). It is unit-testable alone.

Test Plan:
- Reset then req_a=1, addr_a=3 with mux_data modelling bank byte3=0x5C -> mux_sel=3 at cycle 1, ack_a at cycle 2, data_a=0x5C, err_a=0, ack_b never.
- req_a and req_b high continuously, addr_a=1, addr_b=8 -> acks alternate A,B,A,B with 3-cycle spacing; first grant goes to A; data_b=byte8.
- req_b=1, addr_b=12 -> mux_sel stays 0, ack_b with data_b=0x00, err_b=1; next req_b addr_b=2 -> err_b=0.
- req_a=1, addr_a=0 -> data_a=0x00, err_a=0.
- rst_n pulsed low during SEL -> no ack, all outputs reset values within the same cycle, FSM IDLE; a new req_a completes normally.
- With BYTE_RD_ARBITER_STATS_EN: 300 A-only transfers -> gcnt_a=255; 5 contended arbitrations -> conflict_cnt=5.

Source files
------------

// File: rtl/byte_rd_arbiter_pkg.sv
// Shared types and constants for the byte-select read arbiter.
package byte_rd_arbiter_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_SEL_W   = 4;
  localparam int unsigned DEF_MAX_SEL = 8;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/byte_rd_arbiter_rr_pick2.sv
// Two-way round-robin picker: the side that did not win last time wins a tie.
module rr_pick2
  import byte_rd_arbiter_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant_id
);

  // Pick a winner from the current request levels.
  always_comb begin
    grant_valid = req_a | req_b;
    grant_id    = REQ_A;
    if (req_b && (!req_a || (last_grant == REQ_A))) begin
      grant_id = REQ_B;
    end
  end

endmodule

// File: rtl/byte_rd_arbiter.sv
// Round-robin arbiter and sequencer for the shared byte-select read path.
// Optional statistics counters: define BYTE_RD_ARBITER_STATS_EN.
module byte_rd_arbiter
  import byte_rd_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned SEL_W   = DEF_SEL_W,
  parameter int unsigned MAX_SEL = DEF_MAX_SEL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [SEL_W-1:0]  addr_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] data_a,
  output logic              err_a,
  input  logic              req_b,
  input  logic [SEL_W-1:0]  addr_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] data_b,
  output logic              err_b,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic [DATA_W-1:0] mux_data,
`ifdef BYTE_RD_ARBITER_STATS_EN
  output logic [CNT_W-1:0]  gcnt_a,
  output logic [CNT_W-1:0]  gcnt_b,
  output logic [CNT_W-1:0]  conflict_cnt,
`endif
  output logic              busy
);

  state_t            state, state_d;
  req_id_t           winner, winner_d;
  req_id_t           last_grant, last_grant_d;
  logic              clamp, clamp_d;
  logic [SEL_W-1:0]  mux_sel_d;
  logic              ack_a_d, ack_b_d;
  logic [DATA_W-1:0] data_a_d, data_b_d;
  logic              err_a_d, err_b_d;
  logic              busy_d;
  logic              grant_valid;
  req_id_t           grant_id;
  logic [SEL_W-1:0]  pick_addr;
  logic              pick_oor;
  logic [DATA_W-1:0] cap_byte;

  rr_pick2 u_pick (
    .req_a       (req_a),
    .req_b       (req_b),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Winner's address and range check; only consumed in IDLE.
  always_comb begin
    pick_addr = (grant_id == REQ_A) ? addr_a : addr_b;
    pick_oor  = (pick_addr > SEL_W'(MAX_SEL));
    cap_byte  = clamp ? '0 : mux_data;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    winner_d     = winner;
    last_grant_d = last_grant;
    clamp_d      = clamp;
    mux_sel_d    = mux_sel;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    data_a_d     = data_a;
    data_b_d     = data_b;
    err_a_d      = err_a;
    err_b_d      = err_b;
    busy_d       = busy;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          winner_d  = grant_id;
          clamp_d   = pick_oor;
          mux_sel_d = pick_oor ? '0 : pick_addr;
          busy_d    = 1'b1;
          state_d   = SEL;
        end
      end
      SEL: begin
        if (winner == REQ_A) begin
          data_a_d = cap_byte;
          err_a_d  = clamp;
          ack_a_d  = 1'b1;
        end else begin
          data_b_d = cap_byte;
          err_b_d  = clamp;
          ack_b_d  = 1'b1;
        end
        state_d = ACK;
      end
      ACK: begin
        last_grant_d = winner;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      winner     <= REQ_A;
      last_grant <= REQ_B;
      clamp      <= 1'b0;
      mux_sel    <= '0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      data_a     <= '0;
      data_b     <= '0;
      err_a      <= 1'b0;
      err_b      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      winner     <= winner_d;
      last_grant <= last_grant_d;
      clamp      <= clamp_d;
      mux_sel    <= mux_sel_d;
      ack_a      <= ack_a_d;
      ack_b      <= ack_b_d;
      data_a     <= data_a_d;
      data_b     <= data_b_d;
      err_a      <= err_a_d;
      err_b      <= err_b_d;
      busy       <= busy_d;
    end
  end

`ifdef BYTE_RD_ARBITER_STATS_EN
  // Saturating grant and contention counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt_a       <= '0;
      gcnt_b       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (state == ACK && winner == REQ_A) gcnt_a <= sat_inc(gcnt_a);
      if (state == ACK && winner == REQ_B) gcnt_b <= sat_inc(gcnt_b);
      if (state == IDLE && req_a && req_b) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif

endmodule
